// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-port ALU sharing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_share_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_ILL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_LUI = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_arb.sv
// Two-way round-robin picker: one-hot grant, ties go to the port not served last.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant with its own busy state.
// Ports: req[1:0] requests, last = port granted most recently, gnt[1:0] one-hot grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external combinational ALU between two requesters, round-robin.
// Latency: accept in cycle k, ALU evaluates in k+1, response valid from k+2.
// Backpressure: one operation in flight; req_ready stays low until the owner takes the response.
// Ports: p0_*/p1_* request (valid/ready, op, a, b) and response (valid/ready) channels,
//        shared rsp_res/rsp_zero/rsp_ovf/rsp_err, alu_op/alu_a/alu_b to the ALU,
//        alu_res/alu_zero back from it.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [2:0]        p0_op,
    input  logic [DATA_W-1:0] p0_a,
    input  logic [DATA_W-1:0] p0_b,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [2:0]        p1_op,
    input  logic [DATA_W-1:0] p1_a,
    input  logic [DATA_W-1:0] p1_b,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] rsp_res,
    output logic              rsp_zero,
    output logic              rsp_ovf,
    output logic              rsp_err,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero
);

    state_t      state_q;
    state_t      state_nxt;
    logic        last_q;
    logic        own_q;     // 0: port 0 owns the operation in flight, 1: port 1
    logic        ill_q;     // latched op was the illegal opcode
    logic [1:0]  gnt;
    logic        accept;
    logic        rsp_hs;
    logic [2:0]  req_op;
    logic        ovf;

    rr_arb2 u_arb (
        .req  ({p1_req_valid, p0_req_valid}),
        .last (last_q),
        .gnt  (gnt)
    );

    assign p0_req_ready = (state_q == ST_IDLE) & gnt[0];
    assign p1_req_ready = (state_q == ST_IDLE) & gnt[1];
    assign accept       = p0_req_ready | p1_req_ready;
    assign req_op       = gnt[1] ? p1_op : p0_op;
    assign rsp_hs       = (p0_rsp_valid & p0_rsp_ready) | (p1_rsp_valid & p1_rsp_ready);

    // Signed overflow from the operand sign bits; alu_op reads ADD for an
    // illegal op too, so ill_q must veto it.
    always_comb begin
        ovf = 1'b0;
        if (!ill_q) begin
            if (alu_op == OP_ADD) begin
                ovf = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
            end else if (alu_op == OP_SUB) begin
                ovf = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_hs) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            own_q        <= 1'b0;
            ill_q        <= 1'b0;
            alu_op       <= 3'b000;
            alu_a        <= '0;
            alu_b        <= '0;
            rsp_res      <= '0;
            rsp_zero     <= 1'b0;
            rsp_ovf      <= 1'b0;
            rsp_err      <= 1'b0;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                last_q <= gnt[1];
                own_q  <= gnt[1];
                ill_q  <= (req_op == OP_ILL);
                // Illegal op still runs through EXEC, with the ALU parked on ADD.
                alu_op <= (req_op == OP_ILL) ? OP_ADD : req_op;
                alu_a  <= gnt[1] ? p1_a : p0_a;
                alu_b  <= gnt[1] ? p1_b : p0_b;
            end
            if (state_q == ST_EXEC) begin
                rsp_res      <= ill_q ? '0 : alu_res;
                rsp_zero     <= ill_q | alu_zero;
                rsp_ovf      <= ovf;
                rsp_err      <= ill_q;
                p0_rsp_valid <= ~own_q;
                p1_rsp_valid <= own_q;
            end
            if (rsp_hs) begin
                p0_rsp_valid <= 1'b0;
                p1_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        p0_req_valid, p1_req_valid;
    logic        p0_req_ready, p1_req_ready;
    logic [2:0]  p0_op, p1_op;
    logic [31:0] p0_a, p0_b, p1_a, p1_b;
    logic        p0_rsp_valid, p1_rsp_valid;
    logic        p0_rsp_ready, p1_rsp_ready;
    logic [31:0] rsp_res;
    logic        rsp_zero, rsp_ovf, rsp_err;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;

    int n_tests = 0;
    int n_fail  = 0;

    alu_share_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_op(p0_op), .p0_a(p0_a), .p0_b(p0_b),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_op(p1_op), .p1_a(p1_a), .p1_b(p1_b),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
        .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_zero(alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The ALU instance the controller drives.
    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return d;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return a >> b[4:0];
            3'd6:    return {b[15:0], 16'h0000};
            3'd7:    return {31'd0, d[31]};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        alu_res  = alu_f(alu_op, alu_a, alu_b);
        alu_zero = (alu_res == 32'd0);
    end

    // Expected response for a request; overflow from wide signed arithmetic.
    function automatic rsp_t model_rsp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        rsp_t   r;
        int     ia, ib, t;
        longint s;
        ia = a;
        ib = b;
        if (op == 3'd4) begin
            r.res = 32'd0; r.zero = 1'b1; r.ovf = 1'b0; r.err = 1'b1;
            return r;
        end
        r.res  = alu_f(op, a, b);
        r.zero = (r.res == 32'd0);
        r.err  = 1'b0;
        r.ovf  = 1'b0;
        if (op == 3'd0 || op == 3'd1) begin
            s = (op == 3'd0) ? longint'(ia) + longint'(ib) : longint'(ia) - longint'(ib);
            t = int'(s);
            r.ovf = (longint'(t) != s);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + cycle checker ----------------
    bit          m_busy = 0;
    bit          m_last = 1;
    bit          m_fresh = 1;
    int          m_own, m_acc;
    rsp_t        m_exp;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b;
    int          cyc = 0;
    bit          hs0, hs1, rsp_hs_f;
    int          vld_cnt = 0;
    int          busy_rdy_cnt = 0;
    int          acc_q[$];
    int          rq_port[$];
    logic [31:0] rq_res[$];
    int          lr_port, lr_lat;
    logic [31:0] lr_res;
    logic        lr_zero, lr_ovf, lr_err;

    always @(negedge clk) begin
        int   eg;
        logic rv;
        hs0 = 0; hs1 = 0; rsp_hs_f = 0;
        if (p0_rsp_valid || p1_rsp_valid) vld_cnt++;
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_fresh = 1;
            chk("rst p0_rsp_valid", {31'd0, p0_rsp_valid}, 0);
            chk("rst p1_rsp_valid", {31'd0, p1_rsp_valid}, 0);
            chk("rst rsp_res", rsp_res, 0);
            chk("rst flags", {29'd0, rsp_zero, rsp_ovf, rsp_err}, 0);
            chk("rst alu_op", {29'd0, alu_op}, 0);
            chk("rst alu_a", alu_a, 0);
            chk("rst alu_b", alu_b, 0);
        end else begin
            eg = -1;
            if (!m_busy) begin
                if (p0_req_valid && p1_req_valid) eg = m_last ? 0 : 1;
                else if (p0_req_valid)             eg = 0;
                else if (p1_req_valid)             eg = 1;
            end
            if (m_busy && (p0_req_ready || p1_req_ready)) busy_rdy_cnt++;
            chk("p0_req_ready", {31'd0, p0_req_ready}, {31'd0, eg == 0});
            chk("p1_req_ready", {31'd0, p1_req_ready}, {31'd0, eg == 1});
            rv = m_busy && (cyc >= m_acc + 2);
            chk("p0_rsp_valid", {31'd0, p0_rsp_valid}, {31'd0, rv && m_own == 0});
            chk("p1_rsp_valid", {31'd0, p1_rsp_valid}, {31'd0, rv && m_own == 1});
            if (rv) begin
                chk("rsp_res", rsp_res, m_exp.res);
                chk("rsp_zero/ovf/err", {29'd0, rsp_zero, rsp_ovf, rsp_err},
                    {29'd0, m_exp.zero, m_exp.ovf, m_exp.err});
            end else if (m_fresh) begin
                chk("post-rst rsp", {rsp_res[30:0], rsp_zero} | {31'd0, rsp_ovf | rsp_err | rsp_res[31]}, 0);
            end
            if (m_busy && cyc == m_acc + 1) begin
                chk("exec alu_op", {29'd0, alu_op}, {29'd0, (m_op == 3'd4) ? 3'd0 : m_op});
                chk("exec alu_a", alu_a, m_a);
                chk("exec alu_b", alu_b, m_b);
            end
            if (rv && ((m_own == 0) ? p0_rsp_ready : p1_rsp_ready)) begin
                lr_port = m_own; lr_res = rsp_res; lr_zero = rsp_zero;
                lr_ovf = rsp_ovf; lr_err = rsp_err; lr_lat = cyc - m_acc;
                rq_port.push_back(m_own);
                rq_res.push_back(rsp_res);
                m_busy = 0;
                rsp_hs_f = 1;
            end else if (eg >= 0) begin
                m_busy = 1; m_own = eg; m_last = (eg == 1); m_acc = cyc; m_fresh = 0;
                m_op = (eg == 0) ? p0_op : p1_op;
                m_a  = (eg == 0) ? p0_a  : p1_a;
                m_b  = (eg == 0) ? p0_b  : p1_b;
                m_exp = model_rsp(m_op, m_a, m_b);
                acc_q.push_back(eg);
                if (eg == 0) hs0 = 1; else hs1 = 1;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 60) begin @(posedge clk); #1; n++; end
        chk("idle timeout", {31'd0, m_busy}, 0);
    endtask

    task automatic do_req(input int port, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int dly);
        int n;
        if (port == 0) begin
            p0_req_valid = 1; p0_op = op; p0_a = a; p0_b = b; p0_rsp_ready = (dly == 0);
        end else begin
            p1_req_valid = 1; p1_op = op; p1_a = a; p1_b = b; p1_rsp_ready = (dly == 0);
        end
        n = 0;
        do begin @(posedge clk); #1; n++; end
        while (!((port == 0) ? hs0 : hs1) && n < 50);
        chk("req accept timeout", {31'd0, (port == 0) ? hs0 : hs1}, 1);
        if (port == 0) p0_req_valid = 0; else p1_req_valid = 0;
        if (dly > 0) begin
            @(posedge clk);
            repeat (dly) @(posedge clk);
            #1;
            if (port == 0) p0_rsp_ready = 1; else p1_rsp_ready = 1;
        end
        n = 0;
        do begin @(posedge clk); #1; n++; end
        while (!rsp_hs_f && n < 50);
        chk("rsp handshake timeout", {31'd0, rsp_hs_f}, 1);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 15));
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int snap;
        rst_n = 0;
        p0_req_valid = 0; p1_req_valid = 0;
        p0_op = 0; p1_op = 0; p0_a = 0; p0_b = 0; p1_a = 0; p1_b = 0;
        p0_rsp_ready = 1; p1_rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // ADD overflow, latency 2 from accept to response
        do_req(0, 3'd0, 32'h7FFF_FFFF, 32'd1, 0);
        chk("T1 port", lr_port, 0);
        chk("T1 latency", lr_lat, 2);
        chk("T1 res", lr_res, 32'h8000_0000);
        chk("T1 z/o/e", {29'd0, lr_zero, lr_ovf, lr_err}, 32'b010);

        // SUB overflow then SUB to zero on port 1
        do_req(1, 3'd1, 32'h8000_0000, 32'd1, 0);
        chk("T2a res", lr_res, 32'h7FFF_FFFF);
        chk("T2a ovf", {31'd0, lr_ovf}, 1);
        do_req(1, 3'd1, 32'd5, 32'd5, 0);
        chk("T2b res", lr_res, 0);
        chk("T2b z/o/e", {29'd0, lr_zero, lr_ovf, lr_err}, 32'b100);

        // both ports continuously valid: grants alternate starting with p0
        acc_q.delete(); rq_port.delete(); rq_res.delete();
        p0_req_valid = 1; p0_op = 3'd2; p0_a = 32'hF0F0; p0_b = 32'hFF00;
        p1_req_valid = 1; p1_op = 3'd3; p1_a = 32'h0F;   p1_b = 32'hF0;
        n = 0;
        while (rq_port.size() < 4 && n < 100) begin @(posedge clk); #1; n++; end
        p0_req_valid = 0; p1_req_valid = 0;
        wait_idle();
        chk("T3 count", rq_port.size(), 4);
        for (int i = 0; i < 4 && i < rq_port.size() && i < acc_q.size(); i++) begin
            chk("T3 grant order", acc_q[i], i % 2);
            chk("T3 res", rq_res[i], (rq_port[i] == 0) ? 32'hF000 : 32'hFF);
        end

        // SLT with response backpressure while p1 waits
        snap = busy_rdy_cnt;
        p1_req_valid = 1; p1_op = 3'd3; p1_a = 32'd1; p1_b = 32'd2;
        do_req(0, 3'd7, 32'd3, 32'd5, 4);
        chk("T4 port", lr_port, 0);
        chk("T4 res", lr_res, 1);
        chk("T4 latency", lr_lat, 6);
        chk("T4 ready while busy", busy_rdy_cnt, snap);
        n = 0;
        while (m_busy == 0 && p1_req_valid && !hs1 && n < 20) begin @(posedge clk); #1; n++; end
        p1_req_valid = 0;
        wait_idle();

        // illegal opcode
        do_req(1, 3'd4, 32'd7, 32'd9, 0);
        chk("T5 port", lr_port, 1);
        chk("T5 res", lr_res, 0);
        chk("T5 z/o/e", {29'd0, lr_zero, lr_ovf, lr_err}, 32'b101);

        // reset during EXEC of a p0 LUI
        p0_req_valid = 1; p0_op = 3'd6; p0_a = 32'd0; p0_b = 32'h1234;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!hs0 && n < 20);
        chk("T6 accept", {31'd0, hs0}, 1);
        snap = vld_cnt;
        rst_n = 0; p0_req_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("T6 no rsp after rst", vld_cnt, snap);
        p0_req_valid = 1; p0_op = 3'd0; p0_a = 32'd1; p0_b = 32'd2;
        p1_req_valid = 1; p1_op = 3'd0; p1_a = 32'd3; p1_b = 32'd4;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!hs0 && !hs1 && n < 20);
        chk("T6 tie after rst", {31'd0, hs1}, 0);
        chk("T6 tie grant p0", {31'd0, hs0}, 1);
        p0_req_valid = 0;
        n = 0;
        while (!hs1 && n < 20) begin @(posedge clk); #1; n++; end
        p1_req_valid = 0;
        wait_idle();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (hs0 || (p0_req_valid && $urandom_range(0, 19) == 0)) p0_req_valid = 0;
            if (!p0_req_valid && $urandom_range(0, 2) == 0) begin
                p0_req_valid = 1; p0_op = 3'($urandom_range(0, 7));
                p0_a = rnd_opnd(); p0_b = rnd_opnd();
            end
            if (hs1 || (p1_req_valid && $urandom_range(0, 19) == 0)) p1_req_valid = 0;
            if (!p1_req_valid && $urandom_range(0, 2) == 0) begin
                p1_req_valid = 1; p1_op = 3'($urandom_range(0, 7));
                p1_a = rnd_opnd(); p1_b = rnd_opnd();
            end
            p0_rsp_ready = ($urandom_range(0, 2) != 0);
            p1_rsp_ready = ($urandom_range(0, 2) != 0);
        end
        p0_req_valid = 0; p1_req_valid = 0;
        p0_rsp_ready = 1; p1_rsp_ready = 1;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
